// File: rtl/mac_result_drain.sv
// mac_result_drain: captures MACcore column results one cycle after COMP and streams
// rescaled, saturated activations one column per beat. Optional macro RELU_EN clamps negatives to 0.
`default_nettype none

module mac_result_drain #(
  parameter int NCOL  = 16,
  parameter int RES_W = 17,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  comp_in,
  input  logic [NCOL*RES_W-1:0] data_out_bus,
  input  logic [NCOL-1:0]       col_mask,
  input  logic [3:0]            row_tag,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [OUT_W-1:0]      res_data,
  output logic [3:0]            res_col,
  output logic [3:0]            res_row,
  output logic                  res_last,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, SEND = 2'd2, DONE = 2'd3} state_t;

  localparam logic signed [RES_W-1:0] SAT_MAX = RES_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RES_W-1:0] SAT_MIN = RES_W'(-(1 << (OUT_W - 1)));

  state_t                  state_q, state_d;
  logic [NCOL*RES_W-1:0]   data_sh_q, data_sh_d;
  logic [NCOL-1:0]         mask_sh_q, mask_sh_d;
  logic                    res_valid_q, res_valid_d;
  logic [OUT_W-1:0]        res_data_q, res_data_d;
  logic [3:0]              res_col_q, res_col_d;
  logic [3:0]              res_row_q, res_row_d;
  logic                    res_last_q, res_last_d;
  logic                    frame_done_q, frame_done_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic                    xfer;
  logic [3:0]              next_col;
  logic [NCOL-1:0]         mask_rest;

  function automatic logic [3:0] lowest_set(input logic [NCOL-1:0] m);
    lowest_set = '0;
    for (int i = NCOL - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = 4'(i);
    end
  endfunction

  function automatic logic [OUT_W-1:0] rescale(input logic signed [RES_W-1:0] r);
    logic signed [RES_W-1:0] t;
    t = r >>> SHIFT;
    if (t > SAT_MAX) t = SAT_MAX;
    else if (t < SAT_MIN) t = SAT_MIN;
`ifdef RELU_EN
    if (t < 0) t = '0;
`endif
    rescale = t[OUT_W-1:0];
  endfunction

  assign xfer      = res_valid_q && res_ready;
  assign next_col  = lowest_set(mask_sh_q);
  assign mask_rest = mask_sh_q & (mask_sh_q - NCOL'(1));

  always_comb begin
    state_d      = state_q;
    data_sh_d    = data_sh_q;
    mask_sh_d    = mask_sh_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_col_d    = res_col_q;
    res_row_d    = res_row_q;
    res_last_d   = res_last_q;

    // A coincident new overrun beats the clear.
    overrun_d = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;
    if (comp_in && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: if (comp_in) state_d = WAIT;
      WAIT: begin
        data_sh_d = data_out_bus;
        mask_sh_d = col_mask;
        res_row_d = row_tag;
        state_d   = (col_mask != '0) ? SEND : DONE;
      end
      SEND: begin
        if (xfer && res_last_q) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          state_d     = DONE;
        end else if (!res_valid_q || xfer) begin
          // Remaining mask is never empty here: the last beat exits above.
          res_valid_d = 1'b1;
          res_col_d   = next_col;
          res_data_d  = rescale(data_sh_q[int'(next_col)*RES_W +: RES_W]);
          res_last_d  = (mask_rest == '0);
          mask_sh_d   = mask_rest;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    frame_done_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      data_sh_q    <= '0;
      mask_sh_q    <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_col_q    <= '0;
      res_row_q    <= '0;
      res_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_sh_q    <= data_sh_d;
      mask_sh_q    <= mask_sh_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_col_q    <= res_col_d;
      res_row_q    <= res_row_d;
      res_last_q   <= res_last_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_col    = res_col_q;
  assign res_row    = res_row_q;
  assign res_last   = res_last_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire
